// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: two-client round-robin arbiter and sequencer for the shared
// odd-number-accumulation square-root datapath, with an iteration watchdog.
module sqrt_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_ITER = 2 ** (WIDTH / 2)
) (
    input  logic                   clk_i,
    input  logic                   clr_i,
    input  logic                   req0_i,
    input  logic                   req1_i,
    input  logic [WIDTH-1:0]       op0_i,
    input  logic [WIDTH-1:0]       op1_i,
    output logic                   ack0_o,
    output logic                   ack1_o,
    output logic [WIDTH/2-1:0]     root_out_o,
    output logic                   err_o,
    output logic                   busy_o,
    output logic [WIDTH-1:0]       dp_operand_o,
    output logic                   en_a_o,
    output logic                   en_del_o,
    output logic                   en_sq_o,
    output logic                   en_out_o,
    output logic                   ld_add_o,
    input  logic                   greater_i,
    input  logic [WIDTH/2-1:0]     dp_root_i
);

    localparam int unsigned RW = WIDTH / 2;
    localparam int unsigned IW = $clog2(MAX_ITER + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_OUT,
        S_CAPT,
        S_DONE
    } state_t;

    state_t          state_q;
    logic            sel_q;
    logic            last_gnt_q;
    logic [IW-1:0]   iter_q;
    logic            abort_q;
    logic [RW-1:0]   root_out_q;
    logic            err_q;
    logic            ack0_q;
    logic            ack1_q;
    logic            busy_q;

    logic            sel_d;
    logic            run_step;

    // Winner for a new grant: on a tie, the requester not served last time.
    always_comb begin
        sel_d = 1'b0;
        if (req0_i && req1_i) begin
            sel_d = ~last_gnt_q;
        end else begin
            sel_d = req1_i;
        end
    end

    // One accumulate step is allowed while the comparator is low and the watchdog has budget.
    assign run_step = (state_q == S_RUN) && !greater_i && (iter_q < IW'(MAX_ITER));

    // Sequencer state, grant bookkeeping, result capture and acknowledge.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            iter_q     <= '0;
            abort_q    <= 1'b0;
            root_out_q <= '0;
            err_q      <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req0_i || req1_i) begin
                        sel_q   <= sel_d;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    iter_q  <= '0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (greater_i) begin
                        state_q <= S_OUT;
                    end else if (run_step) begin
                        iter_q <= iter_q + IW'(1);
                    end else begin
                        abort_q <= 1'b1;
                        state_q <= S_OUT;
                    end
                end
                S_OUT: begin
                    state_q <= S_CAPT;
                end
                S_CAPT: begin
                    root_out_q <= abort_q ? '1 : dp_root_i;
                    err_q      <= abort_q;
                    last_gnt_q <= sel_q;
                    ack0_q     <= ~sel_q;
                    ack1_q     <= sel_q;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    abort_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath enables: Moore in LOAD/OUT, Mealy on the comparator in RUN.
    always_comb begin
        en_a_o   = 1'b0;
        en_del_o = 1'b0;
        en_sq_o  = 1'b0;
        en_out_o = 1'b0;
        ld_add_o = 1'b0;
        case (state_q)
            S_LOAD: begin
                en_a_o   = 1'b1;
                en_del_o = 1'b1;
                en_sq_o  = 1'b1;
            end
            S_RUN: begin
                en_a_o   = run_step;
                en_del_o = run_step;
                en_sq_o  = run_step;
                ld_add_o = run_step;
            end
            S_OUT: begin
                en_out_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dp_operand_o = sel_q ? op1_i : op0_i;
    assign ack0_o       = ack0_q;
    assign ack1_o       = ack1_q;
    assign root_out_o   = root_out_q;
    assign err_o        = err_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: directed bench for sqrt_arbiter with a behavioural square-root datapath.
module tb_sqrt_arbiter;

    logic       clk;
    logic       clr;
    logic       req0, req1;
    logic [7:0] op0, op1;
    logic       ack0, ack1;
    logic [3:0] root_out;
    logic       err_o;
    logic       busy;
    logic [7:0] dp_operand;
    logic       en_a, en_del, en_sq, en_out, ld_add;
    logic       greater;
    logic [3:0] dp_root;

    int checks;
    int failures;

    // Datapath environment
    logic        stub;
    logic [7:0]  a_m;
    logic [15:0] sq_m;
    logic [15:0] del_m;
    logic [3:0]  root_m;

    sqrt_arbiter #(.WIDTH(8), .MAX_ITER(16)) dut (
        .clk_i        (clk),
        .clr_i        (clr),
        .req0_i       (req0),
        .req1_i       (req1),
        .op0_i        (op0),
        .op1_i        (op1),
        .ack0_o       (ack0),
        .ack1_o       (ack1),
        .root_out_o   (root_out),
        .err_o        (err_o),
        .busy_o       (busy),
        .dp_operand_o (dp_operand),
        .en_a_o       (en_a),
        .en_del_o     (en_del),
        .en_sq_o      (en_sq),
        .en_out_o     (en_out),
        .ld_add_o     (ld_add),
        .greater_i    (greater),
        .dp_root_i    (dp_root)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign greater = stub ? 1'b0 : (sq_m > {8'h00, a_m});
    assign dp_root = root_m;

    always @(posedge clk) begin
        if (clr) begin
            a_m    <= 8'h00;
            sq_m   <= 16'd0;
            del_m  <= 16'd0;
            root_m <= 4'h0;
        end else begin
            if (en_a && !ld_add) a_m <= dp_operand;
            if (en_sq) sq_m <= ld_add ? (sq_m + del_m) : 16'd1;
            if (en_del) del_m <= ld_add ? (del_m + 16'd2) : 16'd3;
            if (en_out) root_m <= 4'(del_m / 16'd2 - 16'd1);
        end
    end

    task automatic apply_clr();
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic idle_gap();
        @(posedge clk);
        #1;
    endtask

    // Steps cycles until the chosen ack; drops that request on ack. cyc = -1 on timeout.
    task automatic wait_ack(input bit which, input int start, input int budget,
                            output int cyc, output bit other, output logic [3:0] root,
                            output logic err, output int accum, output logic [7:0] ld_op);
        cyc = -1; other = 1'b0; root = 4'h0; err = 1'b0; accum = 0; ld_op = 8'h00;
        for (int c = start + 1; c <= start + budget; c++) begin
            @(posedge clk);
            #1;
            if (en_a && ld_add) accum++;
            if (en_a && en_del && en_sq && !ld_add) ld_op = dp_operand;
            if (which ? ack0 : ack1) other = 1'b1;
            if (which ? ack1 : ack0) begin
                cyc  = c;
                root = root_out;
                err  = err_o;
                if (which) req1 = 1'b0; else req0 = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        op0 = 8'h5A; op1 = 8'hA5;
        apply_clr();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({ack0, ack1} !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", {ack0, ack1}); end
        checks++; if (root_out !== 4'h0) begin failures++; $display("FAIL reset_root got=%h exp=0", root_out); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
        checks++; if ({en_a, en_del, en_sq, en_out, ld_add} !== 5'b0) begin failures++; $display("FAIL reset_en got=%b exp=00000", {en_a, en_del, en_sq, en_out, ld_add}); end
        checks++; if (dp_operand !== 8'h5A) begin failures++; $display("FAIL reset_sel_operand got=%h exp=5a", dp_operand); end
    endtask

    task automatic test_tie();
        int cyc; bit other; logic [3:0] root; logic err; int acc; logic [7:0] ldop;
        apply_clr();
        req0 = 1'b1; op0 = 8'd9; req1 = 1'b1; op1 = 8'd25;
        wait_ack(1'b0, 0, 40, cyc, other, root, err, acc, ldop);
        checks++; if (cyc !== 8) begin failures++; $display("FAIL tie_ack0_cycle got=%0d exp=8", cyc); end
        checks++; if (root !== 4'd3) begin failures++; $display("FAIL tie_ack0_root got=%0d exp=3", root); end
        checks++; if (other !== 1'b0) begin failures++; $display("FAIL tie_ack1_early got=%b exp=0", other); end
        wait_ack(1'b1, 8, 40, cyc, other, root, err, acc, ldop);
        checks++; if (cyc !== 19) begin failures++; $display("FAIL tie_ack1_cycle got=%0d exp=19", cyc); end
        checks++; if (root !== 4'd5) begin failures++; $display("FAIL tie_ack1_root got=%0d exp=5", root); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL tie_ack1_err got=%b exp=0", err); end
        idle_gap();
        req0 = 1'b1; op0 = 8'd9; req1 = 1'b1; op1 = 8'd25;
        wait_ack(1'b0, 0, 40, cyc, other, root, err, acc, ldop);
        checks++; if (cyc !== 8) begin failures++; $display("FAIL tie2_ack0_cycle got=%0d exp=8", cyc); end
        checks++; if (other !== 1'b0) begin failures++; $display("FAIL tie2_ack1_first got=%b exp=0", other); end
        wait_ack(1'b1, 8, 40, cyc, other, root, err, acc, ldop);
        checks++; if (root !== 4'd5) begin failures++; $display("FAIL tie2_ack1_root got=%0d exp=5", root); end
        idle_gap();
    endtask

    task automatic test_single();
        int cyc; bit other; logic [3:0] root; logic err; int acc; logic [7:0] ldop;
        req0 = 1'b1; op0 = 8'd16;
        wait_ack(1'b0, 0, 40, cyc, other, root, err, acc, ldop);
        checks++; if (cyc !== 9) begin failures++; $display("FAIL single_cycle got=%0d exp=9", cyc); end
        checks++; if (root !== 4'd4) begin failures++; $display("FAIL single_root got=%0d exp=4", root); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", err); end
        checks++; if (other !== 1'b0) begin failures++; $display("FAIL single_ack1 got=%b exp=0", other); end
        checks++; if (acc !== 4) begin failures++; $display("FAIL single_accum got=%0d exp=4", acc); end
        idle_gap();
        checks++; if ({ack0, busy} !== 2'b00) begin failures++; $display("FAIL single_after_ack got=%b exp=00", {ack0, busy}); end
    endtask

    task automatic test_boundary();
        int cyc; bit other; logic [3:0] root; logic err; int acc; logic [7:0] ldop;
        req0 = 1'b1; op0 = 8'd0;
        wait_ack(1'b0, 0, 40, cyc, other, root, err, acc, ldop);
        checks++; if (cyc !== 5) begin failures++; $display("FAIL zero_cycle got=%0d exp=5", cyc); end
        checks++; if (root !== 4'd0) begin failures++; $display("FAIL zero_root got=%0d exp=0", root); end
        idle_gap();
        req0 = 1'b1; op0 = 8'd255;
        wait_ack(1'b0, 0, 40, cyc, other, root, err, acc, ldop);
        checks++; if (cyc !== 20) begin failures++; $display("FAIL max_cycle got=%0d exp=20", cyc); end
        checks++; if (root !== 4'd15) begin failures++; $display("FAIL max_root got=%0d exp=15", root); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL max_err got=%b exp=0", err); end
        idle_gap();
        req0 = 1'b1; op0 = 8'd224;
        wait_ack(1'b0, 0, 40, cyc, other, root, err, acc, ldop);
        checks++; if (cyc !== 19) begin failures++; $display("FAIL op224_cycle got=%0d exp=19", cyc); end
        checks++; if (root !== 4'd14) begin failures++; $display("FAIL op224_root got=%0d exp=14", root); end
        idle_gap();
    endtask

    task automatic test_watchdog();
        int cyc; bit other; logic [3:0] root; logic err; int acc; logic [7:0] ldop;
        stub = 1'b1;
        req1 = 1'b1; op1 = 8'd100;
        wait_ack(1'b1, 0, 40, cyc, other, root, err, acc, ldop);
        stub = 1'b0;
        checks++; if (acc !== 16) begin failures++; $display("FAIL wd_accum got=%0d exp=16", acc); end
        checks++; if (cyc !== 21) begin failures++; $display("FAIL wd_cycle got=%0d exp=21", cyc); end
        checks++; if (root !== 4'hF) begin failures++; $display("FAIL wd_root got=%h exp=f", root); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL wd_err got=%b exp=1", err); end
        checks++; if (other !== 1'b0) begin failures++; $display("FAIL wd_ack0 got=%b exp=0", other); end
        idle_gap();
        req0 = 1'b1; op0 = 8'd16;
        wait_ack(1'b0, 0, 40, cyc, other, root, err, acc, ldop);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL wd_recover_err got=%b exp=0", err); end
        checks++; if (root !== 4'd4) begin failures++; $display("FAIL wd_recover_root got=%0d exp=4", root); end
        idle_gap();
    endtask

    task automatic test_clr_mid();
        int cyc; bit other; logic [3:0] root; logic err; int acc; logic [7:0] ldop;
        int seen;
        req0 = 1'b1; op0 = 8'd200;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (en_a !== 1'b1 || ld_add !== 1'b1) begin failures++; $display("FAIL clr_in_run got=%b%b exp=11", en_a, ld_add); end
        clr = 1'b1; req0 = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_busy got=%b exp=0", busy); end
        checks++; if ({en_a, en_del, en_sq, en_out, ld_add} !== 5'b0) begin failures++; $display("FAIL clr_en got=%b exp=00000", {en_a, en_del, en_sq, en_out, ld_add}); end
        checks++; if (root_out !== 4'h0) begin failures++; $display("FAIL clr_root got=%h exp=0", root_out); end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (ack0 || ack1) seen++;
            @(posedge clk);
            #1;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL clr_no_ack got=%0d exp=0", seen); end
        req0 = 1'b1; op0 = 8'd49;
        wait_ack(1'b0, 0, 40, cyc, other, root, err, acc, ldop);
        checks++; if (root !== 4'd7) begin failures++; $display("FAIL clr_fresh_root got=%0d exp=7", root); end
        checks++; if (cyc !== 12) begin failures++; $display("FAIL clr_fresh_cycle got=%0d exp=12", cyc); end
        idle_gap();
    endtask

    task automatic test_back_to_back();
        int cyc; bit other; logic [3:0] root; logic err; int acc; logic [7:0] ldop;
        req0 = 1'b1; op0 = 8'd16;
        idle_gap();
        req1 = 1'b1; op1 = 8'd9;
        repeat (2) idle_gap();
        checks++; if (dp_operand !== 8'd16) begin failures++; $display("FAIL b2b_operand_sel got=%0d exp=16", dp_operand); end
        op1 = 8'd81;
        repeat (2) idle_gap();
        op1 = 8'd36;
        wait_ack(1'b0, 5, 40, cyc, other, root, err, acc, ldop);
        checks++; if (cyc !== 9) begin failures++; $display("FAIL b2b_ack0_cycle got=%0d exp=9", cyc); end
        checks++; if (root !== 4'd4) begin failures++; $display("FAIL b2b_ack0_root got=%0d exp=4", root); end
        checks++; if (other !== 1'b0) begin failures++; $display("FAIL b2b_ack1_early got=%b exp=0", other); end
        wait_ack(1'b1, 9, 40, cyc, other, root, err, acc, ldop);
        checks++; if (ldop !== 8'd36) begin failures++; $display("FAIL b2b_load_operand got=%0d exp=36", ldop); end
        checks++; if (cyc !== 21) begin failures++; $display("FAIL b2b_ack1_cycle got=%0d exp=21", cyc); end
        checks++; if (root !== 4'd6) begin failures++; $display("FAIL b2b_ack1_root got=%0d exp=6", root); end
        idle_gap();
    endtask

    initial begin
        checks = 0; failures = 0;
        clr = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = 8'h00; op1 = 8'h00; stub = 1'b0;
        test_reset();
        test_tie();
        test_single();
        test_boundary();
        test_watchdog();
        test_clr_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
